glyph_feeder: RTL and testbench

GLYPH_FEEDER -- requirements
Module: glyph_feeder

---
 rtl/glyph_feeder_if.sv | 14 +
 rtl/glyph_feeder.sv | 149 ++++++++++++++
 tb/tb_glyph_feeder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/glyph_feeder_if.sv
// Character-in / pixel-out handshake bundle for glyph_feeder.
interface glyph_feeder_if;
    logic       char_valid;
    logic [7:0] char_data;
    logic       char_ready;
    logic       pix_valid;
    logic       pix_data;
    logic       pix_ready;

    modport master (output char_valid, char_data, pix_ready,
                    input  char_ready, pix_valid, pix_data);
    modport slave  (input  char_valid, char_data, pix_ready,
                    output char_ready, pix_valid, pix_data);
endinterface

// File: rtl/glyph_feeder.sv
// Buffers an ASCII message and streams one 8x8 glyph (64 pixels) per frame_start.
// Define GLYPH_SERPENTINE_EN to reverse columns on even rows for serpentine strips.
module glyph_feeder #(
    parameter int MSG_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    glyph_feeder_if.slave        bus,
    input  logic                 msg_clear,
    input  logic                 frame_start,
    output logic                 frame_done,
    output logic [5:0]           msg_len
);
    localparam int PW = $clog2(MSG_DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

    state_t        state_q, state_d;
    logic [5:0]    msg_len_q, msg_len_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [5:0]    p_q, p_d;
    logic [63:0]   glyph_q, glyph_d;
    logic [7:0]    msg_q [MSG_DEPTH];
    logic [7:0]    msg_d [MSG_DEPTH];
    logic          rdy_en_q;
    logic          pix_valid_q, pix_valid_d;
    logic          pix_data_q, pix_data_d;
    logic          frame_done_q, frame_done_d;
    logic          wr_en;
    logic [5:0]    rd_nxt;

    function automatic logic [63:0] font(input logic [7:0] c);
        case (c)
            "a": font = 64'h0000780C7CCC7600;
            "b": font = 64'hE060607C6666DC00;
            "c": font = 64'h000078CCC0CC7800;
            "d": font = 64'h1C0C0C7CCCCC7600;
            "e": font = 64'h000078CCFCC07800;
            "f": font = 64'h386C60F06060F000;
            "g": font = 64'h000076CCCC7C0CF8;
            "h": font = 64'hE0606C766666E600;
            "i": font = 64'h3000703030307800;
            "j": font = 64'h0C000C0C0CCCCC78;
            "k": font = 64'hE060666C786CE600;
            "l": font = 64'h7030303030307800;
            "m": font = 64'h0000CCFEFED6C600;
            "n": font = 64'h0000F8CCCCCCCC00;
            "o": font = 64'h000078CCCCCC7800;
            "p": font = 64'h0000DC66667C60F0;
            "q": font = 64'h000076CCCC7C0C1E;
            "r": font = 64'h0000DC766660F000;
            "s": font = 64'h00007CC0780CF800;
            "t": font = 64'h10307C3030341800;
            "u": font = 64'h0000CCCCCCCC7600;
            "v": font = 64'h0000CCCCCC783000;
            "w": font = 64'h0000C6D6FEFE6C00;
            "x": font = 64'h0000C66C386CC600;
            "y": font = 64'h0000CCCCCC7C0CF8;
            "z": font = 64'h0000FC983064FC00;
            default: font = '0;
        endcase
    endfunction

    // Row r occupies bits [63-8r -: 8] with column 0 in the MSB, so pixel n sits at bit 63-n.
    function automatic logic glyph_bit(input logic [63:0] g, input logic [5:0] p);
        logic [2:0] col;
        col = p[2:0];
`ifdef GLYPH_SERPENTINE_EN
        if (!p[3]) col = ~col;
`endif
        glyph_bit = g[~{p[5:3], col}];
    endfunction

    assign bus.char_ready = rdy_en_q & (msg_len_q < 6'(MSG_DEPTH)) & !msg_clear;
    assign wr_en          = bus.char_valid & bus.char_ready;
    assign bus.pix_valid  = pix_valid_q;
    assign bus.pix_data   = pix_data_q;
    assign frame_done     = frame_done_q;
    assign msg_len        = msg_len_q;

    always_comb begin
        state_d   = state_q;
        msg_len_d = msg_len_q;
        rd_ptr_d  = rd_ptr_q;
        p_d       = p_q;
        glyph_d   = glyph_q;
        msg_d     = msg_q;
        rd_nxt    = 6'(rd_ptr_q) + 6'd1;

        if (wr_en) begin
            msg_d[msg_len_q[PW-1:0]] = bus.char_data;
            msg_len_d                = msg_len_q + 6'd1;
        end

        case (state_q)
            IDLE:   if (frame_start) state_d = LOAD;
            LOAD: begin
                glyph_d = (msg_len_q == 6'd0) ? 64'd0 : font(msg_q[rd_ptr_q]);
                p_d     = '0;
                state_d = STREAM;
            end
            STREAM: if (pix_valid_q && bus.pix_ready) begin
                p_d = p_q + 6'd1;
                if (p_q == 6'd63) state_d = DONE;
            end
            DONE: begin
                rd_ptr_d = (rd_nxt >= msg_len_q) ? '0 : PW'(rd_nxt);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Clear wins over the DONE advance so a cleared message restarts at 0.
        if (msg_clear) begin
            msg_len_d = '0;
            rd_ptr_d  = '0;
        end

        frame_done_d = (state_d == DONE);
        pix_valid_d  = (state_d == STREAM);
        pix_data_d   = pix_valid_d & glyph_bit(glyph_d, p_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            msg_len_q    <= '0;
            rd_ptr_q     <= '0;
            p_q          <= '0;
            glyph_q      <= '0;
            msg_q        <= '{default: '0};
            rdy_en_q     <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_data_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            msg_len_q    <= msg_len_d;
            rd_ptr_q     <= rd_ptr_d;
            p_q          <= p_d;
            glyph_q      <= glyph_d;
            msg_q        <= msg_d;
            rdy_en_q     <= 1'b1;
            pix_valid_q  <= pix_valid_d;
            pix_data_q   <= pix_data_d;
            frame_done_q <= frame_done_d;
        end
    end
endmodule

// File: tb/tb_glyph_feeder.sv
// Directed bench for glyph_feeder: frame table plus stall, clear, overflow and reset sequences.
module tb_glyph_feeder;
    localparam logic [63:0] G_H = 64'hE0606C766666E600;
    localparam logic [63:0] G_E = 64'h000078CCFCC07800;
    localparam logic [63:0] G_L = 64'h7030303030307800;
    localparam logic [63:0] G_O = 64'h000078CCCCCC7800;
    localparam logic [63:0] G_A = 64'h0000780C7CCC7600;

    typedef struct {
        string       name;
        logic [63:0] glyph;
    } frame_vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic msg_clear = 1'b0;
    logic frame_start = 1'b0;
    logic frame_done;
    logic [5:0] msg_len;
    int checks = 0;
    int failures = 0;

    glyph_feeder_if bus();

    glyph_feeder #(.MSG_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .msg_clear(msg_clear),
        .frame_start(frame_start), .frame_done(frame_done), .msg_len(msg_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic exp_px(input logic [63:0] g, input int idx);
        int row, col;
        row = idx / 8;
        col = idx % 8;
`ifdef GLYPH_SERPENTINE_EN
        if (row % 2 == 0) col = 7 - col;
`endif
        return g[63 - 8 * row - col];
    endfunction

    task automatic write_char(input logic [7:0] c, input logic exp_rdy, input string nm);
        @(negedge clk);
        bus.char_valid = 1'b1;
        bus.char_data  = c;
        #1 chk(nm, bus.char_ready, exp_rdy);
        @(posedge clk);
        #1 bus.char_valid = 1'b0;
    endtask

    // Streams one frame; abort_at >= 0 asserts reset once that many pixels were accepted.
    task automatic run_frame(input logic [63:0] g, input int stall_at, input int abort_at,
                             input string nm, output logic [63:0] cap);
        logic [63:0] expv;
        int cnt, dn, st, guard;
        cap = '0; cnt = 0; dn = 0; st = 0; guard = 0;
        bus.pix_ready = 1'b1;
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
        chk({nm, "_lat_load"}, bus.pix_valid, 1'b0);
        @(negedge clk);
        chk({nm, "_lat_stream"}, bus.pix_valid, 1'b1);
        while (cnt < 64 && guard < 400) begin
            if (cnt == abort_at) begin
                rst_n = 1'b0;
                #1 chk({nm, "_rst_pix_valid"}, bus.pix_valid, 1'b0);
                chk({nm, "_rst_done"}, frame_done, 1'b0);
                return;
            end
            cap[63 - cnt] = bus.pix_data;
            if (cnt == stall_at && st < 3) begin
                if (st > 0) chk({nm, "_stall_hold"}, bus.pix_data, exp_px(g, cnt));
                bus.pix_ready = 1'b0;
                st++;
            end else begin
                bus.pix_ready = 1'b1;
                if (bus.pix_valid) cnt++;
            end
            @(negedge clk); guard++;
            if (frame_done) dn++;
        end
        if (guard >= 400) chk({nm, "_timeout"}, 64'(guard), 64'd0);
        repeat (2) begin
            @(negedge clk);
            if (frame_done) dn++;
        end
        chk({nm, "_valid_after"}, bus.pix_valid, 1'b0);
        for (int i = 0; i < 64; i++) expv[63 - i] = exp_px(g, i);
        chk({nm, "_pixels"}, cap, expv);
        chk({nm, "_done_count"}, 64'(dn), 64'd1);
    endtask

    initial begin
        frame_vec_t frames[6];
        string msg;
        logic [63:0] cap;
        logic [7:0] row0;

        frames[0] = '{"f_h0", G_H};
        frames[1] = '{"f_e",  G_E};
        frames[2] = '{"f_l0", G_L};
        frames[3] = '{"f_l1", G_L};
        frames[4] = '{"f_o",  G_O};
        frames[5] = '{"f_h1", G_H};
`ifdef GLYPH_SERPENTINE_EN
        row0 = 8'b0000_0111;
`else
        row0 = 8'b1110_0000;
`endif
        bus.char_valid = 1'b0;
        bus.char_data  = '0;
        bus.pix_ready  = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_char_ready", bus.char_ready, 1'b0);
        chk("rst_pix_valid", bus.pix_valid, 1'b0);
        chk("rst_pix_data", bus.pix_data, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_msg_len", msg_len, 6'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", bus.char_ready, 1'b1);

        msg = "hello";
        for (int i = 0; i < 5; i++) write_char(msg[i], 1'b1, "wr_hello");
        chk("hello_len", msg_len, 6'd5);

        for (int f = 0; f < 6; f++) begin
            run_frame(frames[f].glyph, -1, -1, frames[f].name, cap);
            if (f == 0) chk("hello_row0", cap[63:56], row0);
        end

        run_frame(G_E, 10, -1, "stall", cap);

        @(negedge clk);
        msg_clear = 1'b1;
        bus.char_valid = 1'b1;
        bus.char_data  = "z";
        #1 chk("clr_char_ready", bus.char_ready, 1'b0);
        @(posedge clk);
        #1 begin msg_clear = 1'b0; bus.char_valid = 1'b0; end
        @(negedge clk);
        chk("clr_msg_len", msg_len, 6'd0);
        run_frame(64'd0, -1, -1, "blank", cap);

        for (int i = 0; i < 16; i++) write_char(8'h61 + 8'(i), 1'b1, "wr_fill");
        write_char("q", 1'b0, "wr_17th");
        chk("full_len", msg_len, 6'd16);

        run_frame(G_A, -1, 30, "abort", cap);
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_done", frame_done, 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_msg_len", msg_len, 6'd0);
        run_frame(64'd0, -1, -1, "post_abort", cap);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
